// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: op/funct3 encodings, FSM states,
// the latched request payload and small decode helpers.
package mem_access_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned OP_W     = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned CNT_W    = 3;

  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MA_IDLE    = 2'd0,
    MA_ISSUE   = 2'd1,
    MA_CAPTURE = 2'd2,
    MA_DONE    = 2'd3
  } ma_state_t;

  // Request snapshot held for the whole byte-serial sequence.
  typedef struct packed {
    logic                is_store;
    logic [FUNCT3_W-1:0] funct3;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [REG_W-1:0]    wd;
    logic                wreg;
  } ma_req_t;

  // Number of bytes moved for a size code (funct3[1:0]).
  function automatic logic [CNT_W-1:0] byte_count(input logic [1:0] sz);
    case (sz)
      2'b00:   return CNT_W'(1);
      2'b01:   return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  // funct3 codes that actually perform a RAM access.
  function automatic logic f3_valid(input logic is_store, input logic [FUNCT3_W-1:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load result extension: selects/extends the assembled little-endian bytes.
//   funct3  in  load width/sign select
//   raw     in  assembled bytes, byte 0 in [7:0]
//   ext     out extended 32-bit word
module mem_access_load_ext
  import mem_access_pkg::*;
(
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [DATA_W-1:0]   raw,
  output logic [DATA_W-1:0]   ext
);

  always_comb begin
    ext = '0;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_W:    ext = raw;
      F3_BU:   ext = {24'h0, raw[7:0]};
      F3_HU:   ext = {16'h0, raw[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial LOAD/STORE on an 8-bit single-port RAM (read data
// valid one cycle after its address), pipeline stall while busy,
// pass-through of non-memory results, and a forwarding tap.
//   clk, rst                          clock, synchronous active-high reset
//   aluop_i/alufunct3_i/me_i/maddr_i  request from EX/MEM
//   wreg_i/wd_i/wdata_i               destination and ALU result / store data
//   mem_a_o/mem_dout_o/mem_wr_o       RAM address, write byte, write strobe
//   mem_din_i                         RAM read byte
//   stall_req_o                       hold IF..EX/MEM
//   wreg_o/wd_o/wdata_o               to MEM/WB
//   wreg_f/wd_f/wdata_f               forwarding tap
module mem_access
  import mem_access_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     aluop_i,
  input  logic [FUNCT3_W-1:0] alufunct3_i,
  input  logic                me_i,
  input  logic [ADDR_W-1:0]   maddr_i,
  input  logic                wreg_i,
  input  logic [REG_W-1:0]    wd_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [ADDR_W-1:0]   mem_a_o,
  output logic [BYTE_W-1:0]   mem_dout_o,
  output logic                mem_wr_o,
  input  logic [BYTE_W-1:0]   mem_din_i,
  output logic                stall_req_o,
  output logic                wreg_o,
  output logic [REG_W-1:0]    wd_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                wreg_f,
  output logic [REG_W-1:0]    wd_f,
  output logic [DATA_W-1:0]   wdata_f
);

  ma_state_t         state;
  ma_req_t           req;
  logic [CNT_W-1:0]  k;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] ext;

  logic              is_mem;
  logic              is_st_in;
  logic              accept;
  logic [CNT_W-1:0]  last_k;
  logic [1:0]        cap_idx;

  assign is_st_in = (aluop_i == OP_STORE);
  assign is_mem   = me_i && ((aluop_i == OP_LOAD) || is_st_in);
  assign accept   = is_mem && f3_valid(is_st_in, alufunct3_i);
  assign last_k   = byte_count(req.funct3[1:0]) - CNT_W'(1);
  // Read data trails its address by one cycle, so k lands on byte k-1.
  assign cap_idx  = 2'(k - CNT_W'(1));

  mem_access_load_ext u_load_ext (
    .funct3 (req.funct3),
    .raw    (cap),
    .ext    (ext)
  );

  // Sequencer: request latch, byte counter, capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MA_IDLE;
      req   <= '0;
      k     <= '0;
      cap   <= '0;
    end else begin
      case (state)
        MA_IDLE: begin
          if (accept) begin
            req.is_store <= is_st_in;
            req.funct3   <= alufunct3_i;
            req.addr     <= maddr_i;
            req.data     <= wdata_i;
            req.wd       <= wd_i;
            req.wreg     <= wreg_i;
            k            <= '0;
            cap          <= '0;
            state        <= MA_ISSUE;
          end
        end
        MA_ISSUE: begin
          if (!req.is_store && (k != '0)) cap[{cap_idx, 3'b000} +: BYTE_W] <= mem_din_i;
          k <= k + CNT_W'(1);
          if (k == last_k) state <= req.is_store ? MA_DONE : MA_CAPTURE;
        end
        MA_CAPTURE: begin
          cap[{cap_idx, 3'b000} +: BYTE_W] <= mem_din_i;
          state <= MA_DONE;
        end
        MA_DONE: state <= MA_IDLE;
        default: state <= MA_IDLE;
      endcase
    end
  end

  // Output decode; IDLE pass-through is combinational from the inputs.
  always_comb begin
    mem_a_o     = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;
    stall_req_o = 1'b0;
    wreg_o      = 1'b0;
    wd_o        = '0;
    wdata_o     = '0;
    if (!rst) begin
      case (state)
        MA_IDLE: begin
          if (accept) begin
            stall_req_o = 1'b1;
          end else if (!is_mem) begin
            wreg_o  = wreg_i;
            wd_o    = wd_i;
            wdata_o = wdata_i;
          end
        end
        MA_ISSUE: begin
          stall_req_o = 1'b1;
          mem_a_o     = req.addr + ADDR_W'(k);
          if (req.is_store) begin
            mem_wr_o   = 1'b1;
            mem_dout_o = req.data[{k[1:0], 3'b000} +: BYTE_W];
          end
        end
        MA_CAPTURE: stall_req_o = 1'b1;
        MA_DONE: begin
          wd_o = req.wd;
          if (!req.is_store) begin
            wreg_o  = req.wreg;
            wdata_o = ext;
          end
        end
        default: ;
      endcase
    end
  end

  // Forwarding never advertises a write while the pipeline is held.
  assign wreg_f  = wreg_o & ~stall_req_o;
  assign wd_f    = wd_o;
  assign wdata_f = wdata_o;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [6:0] LOAD  = 7'h03;
  localparam logic [6:0] STORE = 7'h23;
  localparam logic [6:0] ADD   = 7'h33;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  aluop_i = '0;
  logic [2:0]  alufunct3_i = '0;
  logic        me_i = 1'b0;
  logic [31:0] maddr_i = '0;
  logic        wreg_i = 1'b0;
  logic [4:0]  wd_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic [7:0]  mem_din_i;
  logic        stall_req_o;
  logic        wreg_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;
  logic        wreg_f;
  logic [4:0]  wd_f;
  logic [31:0] wdata_f;

  int nvec = 0;
  int nerr = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop_i), .alufunct3_i(alufunct3_i), .me_i(me_i), .maddr_i(maddr_i),
    .wreg_i(wreg_i), .wd_i(wd_i), .wdata_i(wdata_i),
    .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i),
    .stall_req_o(stall_req_o),
    .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o),
    .wreg_f(wreg_f), .wd_f(wd_f), .wdata_f(wdata_f)
  );

  always #5 clk = ~clk;

  // RAM: 1 KiB aliased over the 32-bit space, one-cycle read latency.
  logic [7:0] ram [1024];
  logic [7:0] rd_q;
  logic       clr = 1'b0, pl_en = 1'b0;
  logic [9:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  int         wr_cnt = 0;
  assign mem_din_i = rd_q;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    end else if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_wr_o) begin
      ram[mem_a_o[9:0]] <= mem_dout_o;
    end
    if (mem_wr_o) wr_cnt <= wr_cnt + 1;
    rd_q <= ram[mem_a_o[9:0]];
  end

  // Reference memory image.
  logic [7:0] mdl [1024];

  function automatic int ix(input logic [31:0] a);
    return int'(a[9:0]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pl_a = a[9:0]; pl_d = d; pl_en = 1'b1;
    mdl[ix(a)] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Transaction-level model: stall length, result and RAM effect.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic me,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic wreg,
                       output int st, output logic xw, output logic [31:0] xd,
                       output logic full, output int wr);
    int n;
    bit ld, sd, ldok, sdok;
    logic [31:0] v;
    n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ld   = me && (op == LOAD);
    sd   = me && (op == STORE);
    ldok = ld && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sdok = sd && (f3 <= 3'd2);
    st = 0; xw = wreg; xd = wdata; full = 1'b1; wr = 0;
    if (ldok) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl[ix(addr + 32'(i))]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      st = n + 2; xd = v;
    end else if (sdok) begin
      for (int i = 0; i < n; i++) mdl[ix(addr + 32'(i))] = wdata[8*i +: 8];
      st = n + 1; xw = 1'b0; xd = 32'h0; wr = n;
    end else if (ld || sd) begin
      xw = 1'b0; full = 1'b0;
    end
  endtask

  // Apply one request, hold it through the stall, check the result cycle.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic me,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wd, input logic wreg,
                         input int xst, input logic xw, input logic [31:0] xd,
                         input logic full, input int xwr);
    int st, wr0;
    aluop_i = op; alufunct3_i = f3; me_i = me; maddr_i = addr;
    wdata_i = wdata; wd_i = wd; wreg_i = wreg;
    wr0 = wr_cnt; st = 0;
    @(negedge clk);
    while (stall_req_o === 1'b1 && st < 20) begin
      chk("wreg_f_in_stall", 32'(wreg_f), 32'h0);
      st++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(st), 32'(xst));
    chk("wreg_o", 32'(wreg_o), 32'(xw));
    chk("wreg_f", 32'(wreg_f), 32'(xw));
    if (full) begin
      chk("wdata_o", wdata_o, xd);
      chk("wd_o", 32'(wd_o), 32'(wd));
      chk("wdata_f", wdata_f, xd);
      chk("wd_f", 32'(wd_f), 32'(wd));
    end
    @(posedge clk); #1;
    chk("ram_writes", 32'(wr_cnt - wr0), 32'(xwr));
  endtask

  task automatic check_ram(input logic [31:0] addr, input int n);
    for (int i = 0; i <= n; i++)
      chk("ram_byte", 32'(ram[ix(addr + 32'(i))]), 32'(mdl[ix(addr + 32'(i))]));
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        me;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    int          st;
    logic        xw;
    logic [31:0] xd;
    logic        full;
    int          wr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int          st, wr0;
    logic        xw, full;
    logic [31:0] xd;

    tbl[0]  = '{LOAD,  3'd2, 1'b1, 32'h0000_0100, 32'h0,         5'd1,  1'b1, 6, 1'b1, 32'h1234_5678, 1'b1, 0};
    tbl[1]  = '{LOAD,  3'd0, 1'b1, 32'h0000_0040, 32'h0,         5'd2,  1'b1, 3, 1'b1, 32'hFFFF_FF80, 1'b1, 0};
    tbl[2]  = '{LOAD,  3'd4, 1'b1, 32'h0000_0040, 32'h0,         5'd3,  1'b1, 3, 1'b1, 32'h0000_0080, 1'b1, 0};
    tbl[3]  = '{STORE, 3'd1, 1'b1, 32'h0000_0203, 32'hABCD_BEEF, 5'd4,  1'b1, 3, 1'b0, 32'h0,         1'b1, 2};
    tbl[4]  = '{LOAD,  3'd5, 1'b1, 32'h0000_0203, 32'h0,         5'd5,  1'b1, 4, 1'b1, 32'h0000_BEEF, 1'b1, 0};
    tbl[5]  = '{ADD,   3'd0, 1'b0, 32'h0,         32'h5,         5'd3,  1'b1, 0, 1'b1, 32'h5,         1'b1, 0};
    tbl[6]  = '{LOAD,  3'd1, 1'b1, 32'h0000_0040, 32'h0,         5'd6,  1'b1, 4, 1'b1, 32'hFFFF_9080, 1'b1, 0};
    tbl[7]  = '{LOAD,  3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0,         5'd7,  1'b1, 4, 1'b1, 32'h0000_11AA, 1'b1, 0};
    tbl[8]  = '{LOAD,  3'd3, 1'b1, 32'h0000_0100, 32'h0,         5'd8,  1'b1, 0, 1'b0, 32'h0,         1'b0, 0};
    tbl[9]  = '{STORE, 3'd5, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9,  1'b1, 0, 1'b0, 32'h0,         1'b0, 0};
    tbl[10] = '{LOAD,  3'd2, 1'b0, 32'h0000_0100, 32'h77,        5'd10, 1'b1, 0, 1'b1, 32'h77,        1'b1, 0};
    tbl[11] = '{LOAD,  3'd2, 1'b1, 32'h0000_0100, 32'h0,         5'd11, 1'b0, 6, 1'b0, 32'h1234_5678, 1'b1, 0};
    tbl[12] = '{STORE, 3'd0, 1'b1, 32'h0000_0041, 32'h1234_5655, 5'd12, 1'b1, 2, 1'b0, 32'h0,         1'b1, 1};
    tbl[13] = '{LOAD,  3'd0, 1'b1, 32'h0000_0041, 32'h0,         5'd13, 1'b1, 3, 1'b1, 32'h0000_0055, 1'b1, 0};

    for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;

    // Reset with a live ALU result on the inputs: everything must be 0.
    rst = 1'b1; clr = 1'b1;
    aluop_i = ADD; wreg_i = 1'b1; wd_i = 5'd3; wdata_i = 32'h5;
    @(posedge clk); #1;
    clr = 1'b0;
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h040, 8'h80); preload(32'h041, 8'h90);
    preload(32'h3FF, 8'hAA); preload(32'h000, 8'h11);
    @(negedge clk);
    chk("rst_stall", 32'(stall_req_o), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr_o), 32'h0);
    chk("rst_wreg_o", 32'(wreg_o), 32'h0);
    chk("rst_wreg_f", 32'(wreg_f), 32'h0);
    chk("rst_wdata_o", wdata_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, applied back to back.
    for (int i = 0; i < 14; i++) begin
      model(tbl[i].op, tbl[i].f3, tbl[i].me, tbl[i].addr, tbl[i].wdata, tbl[i].wreg,
            st, xw, xd, full, wr0);
      run_txn(tbl[i].op, tbl[i].f3, tbl[i].me, tbl[i].addr, tbl[i].wdata, tbl[i].wd,
              tbl[i].wreg, tbl[i].st, tbl[i].xw, tbl[i].xd, tbl[i].full, tbl[i].wr);
      if (tbl[i].wr != 0) check_ram(tbl[i].addr, tbl[i].wr);
    end

    // Reset in the middle of a word store: only byte 0 reaches RAM.
    aluop_i = STORE; alufunct3_i = 3'd2; me_i = 1'b1; maddr_i = 32'h10;
    wdata_i = 32'hA1B2_C3D4; wd_i = 5'd0; wreg_i = 1'b0;
    wr0 = wr_cnt;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_stall", 32'(stall_req_o), 32'h0);
    chk("rstmid_mem_wr", 32'(mem_wr_o), 32'h0);
    chk("rstmid_mem_a", mem_a_o, 32'h0);
    chk("rstmid_wreg_f", 32'(wreg_f), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    aluop_i = ADD; me_i = 1'b0; wdata_i = 32'h0; wd_i = 5'd0; wreg_i = 1'b0;
    @(negedge clk);
    chk("after_rst_stall", 32'(stall_req_o), 32'h0);
    chk("after_rst_mem_wr", 32'(mem_wr_o), 32'h0);
    chk("after_rst_wreg_o", 32'(wreg_o), 32'h0);
    chk("after_rst_writes", 32'(wr_cnt - wr0), 32'h1);
    mdl[16] = 8'hD4;
    check_ram(32'h10, 3);
    @(posedge clk); #1;

    // Randomized back-to-back traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        me, wreg;
      logic [31:0] addr, wdata;
      logic [4:0]  wd;
      int          sel;
      sel   = int'($urandom_range(0, 2));
      op    = (sel == 0) ? LOAD : (sel == 1) ? STORE : ADD;
      f3    = 3'($urandom_range(0, 7));
      me    = ($urandom_range(0, 7) != 0);
      addr  = $urandom;
      wdata = $urandom;
      wd    = 5'($urandom_range(0, 31));
      wreg  = 1'($urandom_range(0, 1));
      model(op, f3, me, addr, wdata, wreg, st, xw, xd, full, wr0);
      run_txn(op, f3, me, addr, wdata, wd, wreg, st, xw, xd, full, wr0);
      if (wr0 != 0) check_ram(addr, wr0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
